keypad_scan: RTL and testbench

//   4x4 matrix keypad scanner/encoder: drives columns, samples rows, debounces, and

---
 rtl/keypad_scan.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan - 4x4 matrix keypad scanner and encoder.
//
// Drives the keypad columns one at a time (active-low) and samples the rows
// once per column dwell. A key is accepted after DEBOUNCE_SCANS consecutive
// identical samples. Each accepted press produces one key_valid pulse
// carrying its code on key_value. A press is released after DEBOUNCE_SCANS
// consecutive all-high samples.
//
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat. A held
// key then re-pulses key_valid after REPEAT_DELAY samples, and again every
// REPEAT_RATE samples until release begins. With the macro undefined, each
// press yields exactly one pulse and the REPEAT_* parameters have no effect.
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  asynchronous reset, active-high
//   row_in     in   4  keypad rows, active-low, asynchronous to clk
//   col_out    out  4  keypad columns, one-hot active-low
//   key_value  out  4  code of the last accepted key
//   key_valid  out  1  one-cycle pulse, key_value valid in the same cycle
//   key_held   out  1  high from acceptance until release debounce completes

module keypad_scan #(
  parameter int SCAN_CYC       = 50000,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_CYC);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  // Illegal values would break the dwell/debounce arithmetic,
  // so they are rejected at elaboration time.
  if (SCAN_CYC < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : gParamCheck
    $error("keypad_scan: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      rowMeta_q, rowSync_q;
  logic [DW-1:0]   dwell_q;
  logic [3:0]      col_q, col_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      pat_q, pat_d;
  logic [3:0]      keyValue_q, keyValue_d;
  logic            keyValid_q, keyValid_d;
  logic            keyHeld_q, keyHeld_d;

  logic            sample;
  logic [3:0]      colNext;
  logic [CW-1:0]   cntInc;
  logic            cntDone;
  logic [3:0]      keyCode;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0]   repCnt_q, repCnt_d;
  logic            repStarted_q, repStarted_d;
  logic [RW-1:0]   repInc;
  logic            repFire;
`endif

  // True when exactly one row is pulled low; anything else (idle or ghosting) is no key.
  function automatic logic validRow(input logic [3:0] rows);
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Position of the single low bit in a one-hot active-low vector.
  function automatic logic [1:0] lowIndex(input logic [3:0] v);
    case (v)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] keyMap(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hF;
      4'hD: return 4'h0;
      4'hE: return 4'hE;
      4'hF: return 4'hD;
    endcase
  endfunction

  // Two-flop synchroniser; idle rows read high, so that is the reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rowMeta_q <= 4'hF;
      rowSync_q <= 4'hF;
    end else begin
      rowMeta_q <= row_in;
      rowSync_q <= rowMeta_q;
    end
  end

  // Free-running dwell counter; the terminal count marks the sample cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
    end else if (sample) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

  assign sample  = (dwell_q == DW'(SCAN_CYC - 1));
  assign colNext = {col_q[2:0], col_q[3]};
  assign cntInc  = (cnt_q == CW'(DEBOUNCE_SCANS)) ? cnt_q : cnt_q + 1'b1;
  assign cntDone = (cntInc == CW'(DEBOUNCE_SCANS));
  // The frozen column plus the current row pattern identify the key.
  assign keyCode = keyMap(lowIndex(rowSync_q), lowIndex(col_q));

`ifdef KEYPAD_REPEAT_EN
  assign repInc  = (repCnt_q == RW'(RMAX)) ? repCnt_q : repCnt_q + 1'b1;
  assign repFire = repStarted_q ? (repInc == RW'(REPEAT_RATE)) : (repInc == RW'(REPEAT_DELAY));
`endif

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    keyValue_d = keyValue_q;
    keyValid_d = 1'b0;
    keyHeld_d  = keyHeld_q;
`ifdef KEYPAD_REPEAT_EN
    repCnt_d     = repCnt_q;
    repStarted_d = repStarted_q;
`endif
    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (validRow(rowSync_q)) begin
            pat_d = rowSync_q;
            // With a single-sample debounce the detection sample is the acceptance.
            if (DEBOUNCE_SCANS == 1) begin
              cnt_d      = CW'(DEBOUNCE_SCANS);
              keyValue_d = keyCode;
              keyValid_d = 1'b1;
              keyHeld_d  = 1'b1;
              state_d    = ST_PRESSED;
            end else begin
              cnt_d   = CW'(1);
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = colNext;
          end
        end
        ST_DEBOUNCE: begin
          if (rowSync_q == pat_q) begin
            cnt_d = cntInc;
            if (cntDone) begin
              keyValue_d = keyCode;
              keyValid_d = 1'b1;
              keyHeld_d  = 1'b1;
              state_d    = ST_PRESSED;
            end
          end else begin
            cnt_d   = '0;
            col_d   = colNext;
            state_d = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (rowSync_q == 4'hF) begin
`ifdef KEYPAD_REPEAT_EN
            repCnt_d     = '0;
            repStarted_d = 1'b0;
`endif
            if (DEBOUNCE_SCANS == 1) begin
              cnt_d     = '0;
              keyHeld_d = 1'b0;
              col_d     = colNext;
              state_d   = ST_SCAN;
            end else begin
              cnt_d   = CW'(1);
              state_d = ST_RELEASE;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rowSync_q == pat_q) begin
            if (repFire) begin
              keyValid_d   = 1'b1;
              repCnt_d     = '0;
              repStarted_d = 1'b1;
            end else begin
              repCnt_d = repInc;
            end
          end
`else
          // Without auto-repeat, anything short of a full release is ignored while held.
`endif
        end
        ST_RELEASE: begin
          if (rowSync_q == 4'hF) begin
            cnt_d = cntInc;
            if (cntDone) begin
              cnt_d     = '0;
              keyHeld_d = 1'b0;
              col_d     = colNext;
              state_d   = ST_SCAN;
            end
          end else begin
            // A bounce during release keeps the key held without a new pulse.
            cnt_d   = '0;
            state_d = ST_PRESSED;
          end
        end
        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      col_q      <= 4'b1110;
      cnt_q      <= '0;
      pat_q      <= 4'hF;
      keyValue_q <= 4'h0;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      keyValue_q <= keyValue_d;
      keyValid_q <= keyValid_d;
      keyHeld_q  <= keyHeld_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repCnt_q     <= '0;
      repStarted_q <= 1'b0;
    end else begin
      repCnt_q     <= repCnt_d;
      repStarted_q <= repStarted_d;
    end
  end
`endif

  assign col_out   = col_q;
  assign key_value = keyValue_q;
  assign key_valid = keyValid_q;
  assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan - directed testbench for keypad_scan.
// A behavioural keypad drives the rows from the pressed-key mask and the DUT
// column drive. Expected key codes are queued when a key is pressed. Every
// key_valid pulse seen by the monitor is compared in order against that queue.

module tb_keypad_scan;

  localparam int SCAN_CYC       = 4;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int REPEAT_DELAY   = 5;
  localparam int REPEAT_RATE    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rowIn;
  logic [3:0]  colOut;
  logic [3:0]  keyValue;
  logic        keyValid;
  logic        keyHeld;

  logic [15:0] pressMask;
  logic [3:0]  keyTable [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hF, 4'h0, 4'hE, 4'hD};

  logic [3:0]  expQ [$];
  logic [3:0]  obsQ [$];
  int          obsIdx      = 0;
  int          expTotal    = 0;
  int          assertCount = 0;
  int          failCount   = 0;
  int          b2bErr      = 0;
  int          valueErr    = 0;
  logic        prevValid;
  logic [3:0]  prevValue;
  int          repeatPulses;

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_CYC      (SCAN_CYC),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_RATE   (REPEAT_RATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (rowIn),
    .col_out  (colOut),
    .key_value(keyValue),
    .key_valid(keyValid),
    .key_held (keyHeld)
  );

  // Keypad model: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    rowIn = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressMask[r*4+c] && (colOut[c] === 1'b0)) begin
          rowIn[r] = 1'b0;
        end
      end
    end
  end

  // Pulse monitor: records every key_valid and flags protocol breaches.
  always begin
    @(negedge clk);
    #1;
    if (rst !== 1'b0) begin
      prevValid = 1'b0;
      prevValue = keyValue;
    end else begin
      if (keyValid === 1'b1) begin
        obsQ.push_back(keyValue);
        if (prevValid) b2bErr++;
      end else if (keyValue !== prevValue) begin
        valueErr++;
      end
      prevValid = keyValid;
      prevValue = keyValue;
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitPulse(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (keyValid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, " pulse seen"}, 32'(seen), 32'd1);
    if (seen) checkOutput({tag, " held at pulse"}, 32'(keyHeld), 32'd1);
  endtask

  task automatic waitHeldFall(input string tag, input int budget, output bit fell);
    fell = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (keyHeld === 1'b0) begin
        fell = 1'b1;
        break;
      end
    end
    checkOutput({tag, " held released"}, 32'(fell), 32'd1);
  endtask

  task automatic waitCol(input string tag, input logic [3:0] pattern, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (colOut === pattern) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, " column reached"}, 32'(seen), 32'd1);
  endtask

  // Compares the pulses observed since the last drain with the queued expectations.
  task automatic drainScoreboard(input string tag);
    checkOutput({tag, " pulse count"}, 32'(obsQ.size() - obsIdx), 32'(expQ.size()));
    while (expQ.size() > 0 && obsIdx < obsQ.size()) begin
      checkOutput({tag, " key_value"}, 32'(obsQ[obsIdx]), 32'(expQ.pop_front()));
      obsIdx++;
    end
    expQ.delete();
    obsIdx = obsQ.size();
  endtask

  // Press key (r,c), hold it extraHold cycles past acceptance, release, and check the aftermath.
  task automatic applyStimulus(input int r, input int c, input int extraHold, input int nExp, input string tag);
    logic [3:0] expCol;
    bit fell;
    for (int k = 0; k < nExp; k++) begin
      expQ.push_back(keyTable[r*4+c]);
      expTotal++;
    end
    pressMask[r*4+c] = 1'b1;
    waitPulse(tag, 80);
    stepCycles(extraHold);
    pressMask[r*4+c] = 1'b0;
    stepCycles(6);
    checkOutput({tag, " held during release debounce"}, 32'(keyHeld), 32'd1);
    waitHeldFall(tag, 60, fell);
    expCol = 4'hF;
    expCol[(c+1)%4] = 1'b0;
    if (fell) checkOutput({tag, " scan resumes at next column"}, 32'(colOut), 32'(expCol));
    drainScoreboard(tag);
  endtask

  int seqR [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 0};
  int seqC [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 3};

  initial begin
`ifdef KEYPAD_REPEAT_EN
    repeatPulses = 3;
`else
    repeatPulses = 1;
`endif
    rst       = 1'b0;
    pressMask = 16'h0000;
    #2;
    rst = 1'b1;
    @(negedge clk);
    $display("[TB] reset values");
    checkOutput("reset col_out", 32'(colOut), 32'hE);
    checkOutput("reset key_valid", 32'(keyValid), 32'd0);
    checkOutput("reset key_value", 32'(keyValue), 32'd0);
    checkOutput("reset key_held", 32'(keyHeld), 32'd0);
    rst = 1'b0;

    $display("[TB] column rotation");
    stepCycles(4);
    checkOutput("rotate col1", 32'(colOut), 32'hD);
    stepCycles(4);
    checkOutput("rotate col2", 32'(colOut), 32'hB);
    stepCycles(4);
    checkOutput("rotate col3", 32'(colOut), 32'h7);

    $display("[TB] single press of 6");
    applyStimulus(1, 2, 20, 1, "key6");

    $display("[TB] bouncing 5");
    for (int i = 0; i < 40; i++) begin
      pressMask[5] = ~pressMask[5];
      stepCycles(3);
    end
    pressMask = 16'h0000;
    stepCycles(30);
    drainScoreboard("bounce5");
    checkOutput("bounce5 key_held", 32'(keyHeld), 32'd0);

    $display("[TB] ghosting r0+r2 on c0");
    pressMask[0] = 1'b1;
    pressMask[8] = 1'b1;
    stepCycles(60);
    pressMask = 16'h0000;
    stepCycles(20);
    drainScoreboard("ghost");
    checkOutput("ghost key_held", 32'(keyHeld), 32'd0);

    $display("[TB] sequence 1..8,A");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(seqR[i], seqC[i], 4, 1, $sformatf("seq%0d", i));
    end

    $display("[TB] reset during debounce of B");
    waitCol("rstB pre", 4'hB, 40);
    pressMask[7] = 1'b1;
    waitCol("rstB", 4'h7, 40);
    stepCycles(6);
    rst = 1'b1;
    pressMask = 16'h0000;
    stepCycles(1);
    checkOutput("rstB col_out", 32'(colOut), 32'hE);
    checkOutput("rstB key_valid", 32'(keyValid), 32'd0);
    checkOutput("rstB key_value", 32'(keyValue), 32'd0);
    checkOutput("rstB key_held", 32'(keyHeld), 32'd0);
    rst = 1'b0;
    stepCycles(40);
    drainScoreboard("rstB");

    $display("[TB] held 3 for repeat window");
    applyStimulus(0, 2, 32, repeatPulses, "hold3");

    checkOutput("total pulses", 32'(obsQ.size()), 32'(expTotal));
    checkOutput("no back-to-back key_valid", 32'(b2bErr), 32'd0);
    checkOutput("key_value stable without key_valid", 32'(valueErr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
